// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and constants.
package riscv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned PERF_STALL_W = 32;
  localparam int unsigned PERF_FLUSH_W = 16;

  localparam logic [PERF_FLUSH_W-1:0] PERF_FLUSH_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    FLUSH    = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: ID/EX/LSU status in, stall/flush/redirect/perf out.
interface pipe_ctrl_if;
  import riscv_pkg::*;

  logic                    id_valid;
  logic [REG_ADDR_W-1:0]   id_rs1_addr;
  logic [REG_ADDR_W-1:0]   id_rs2_addr;
  logic                    id_rs1_used;
  logic                    id_rs2_used;
  logic                    load_instr_in_ex;
  logic [REG_ADDR_W-1:0]   ex_dest_we_addr;
  logic                    ex_stage_ready;
  logic                    branch_taken;
  logic [XLEN-1:0]         branch_target_addr;
  logic                    id_jump;
  logic [XLEN-1:0]         jump_target_addr;
  logic                    mem_lsu_valid;
  logic                    mem_lsu_wr_type;
  logic                    data_gnt;
  logic                    data_rvalid;

  logic                    stall_if;
  logic                    stall_id;
  logic                    stall_ex_stage;
  logic                    flush_if;
  logic                    flush_id;
  logic                    pc_set;
  logic [XLEN-1:0]         pc_set_addr;
  logic [PERF_STALL_W-1:0] perf_stall_cnt;
  logic [PERF_FLUSH_W-1:0] perf_flush_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           load_instr_in_ex, ex_dest_we_addr, ex_stage_ready,
           branch_taken, branch_target_addr, id_jump, jump_target_addr,
           mem_lsu_valid, mem_lsu_wr_type, data_gnt, data_rvalid,
    input  stall_if, stall_id, stall_ex_stage, flush_if, flush_id,
           pc_set, pc_set_addr, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           load_instr_in_ex, ex_dest_we_addr, ex_stage_ready,
           branch_taken, branch_target_addr, id_jump, jump_target_addr,
           mem_lsu_valid, mem_lsu_wr_type, data_gnt, data_rvalid,
    output stall_if, stall_id, stall_ex_stage, flush_if, flush_id,
           pc_set, pc_set_addr, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_unit.sv
// Combinational load-use detector: a load in EX writing a register ID reads.
module pipe_hazard_unit
  import riscv_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  load_instr_in_ex,
  input  logic [REG_ADDR_W-1:0] ex_dest_we_addr,
  output logic                  load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real destination, so it cannot create a hazard.
  always_comb begin
    rs1_hit    = id_rs1_used && (id_rs1_addr == ex_dest_we_addr);
    rs2_hit    = id_rs2_used && (id_rs2_addr == ex_dest_we_addr);
    load_use_c = load_instr_in_ex && id_valid &&
                 (ex_dest_we_addr != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: LSU stall FSM, branch/jump redirect, load-use bubble, perf counters.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter logic [PERF_STALL_W-1:0] PERF_STALL_RST = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  pipe_ctrl_if.slave  bus
);

  pipe_state_e             state_q, state_d;
  logic [PERF_STALL_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [PERF_FLUSH_W-1:0] perf_flush_cnt_q, perf_flush_cnt_d;

  logic            load_use_c;
  logic            lsu_stall_c;
  logic            lu_stall_c;
  logic            stall_if_c;
  logic            stall_id_c;
  logic            stall_ex_c;
  logic            flush_if_c;
  logic            flush_id_c;
  logic            pc_set_c;
  logic [XLEN-1:0] pc_set_addr_c;
  logic            lsu_pend_c;
  logic            lsu_load_gnt_c;

  pipe_hazard_unit u_hazard (
    .id_valid         (bus.id_valid),
    .id_rs1_addr      (bus.id_rs1_addr),
    .id_rs2_addr      (bus.id_rs2_addr),
    .id_rs1_used      (bus.id_rs1_used),
    .id_rs2_used      (bus.id_rs2_used),
    .load_instr_in_ex (bus.load_instr_in_ex),
    .ex_dest_we_addr  (bus.ex_dest_we_addr),
    .load_use_c       (load_use_c)
  );

  // Next state and outputs; branch/jump/load-use only act in RUN when the LSU is not stalling.
  always_comb begin
    state_d        = state_q;
    lsu_stall_c    = 1'b0;
    lu_stall_c     = 1'b0;
    flush_if_c     = 1'b0;
    flush_id_c     = 1'b0;
    pc_set_c       = 1'b0;
    pc_set_addr_c  = '0;
    lsu_pend_c     = bus.mem_lsu_valid && !bus.data_gnt;
    lsu_load_gnt_c = bus.mem_lsu_valid && bus.data_gnt && !bus.mem_lsu_wr_type;

    case (state_q)
      RUN, FLUSH: begin
        if (lsu_pend_c) begin
          lsu_stall_c = 1'b1;
          state_d     = LSU_REQ;
        end else begin
          state_d = lsu_load_gnt_c ? LSU_WAIT : RUN;
          if (state_q == RUN) begin
            if (bus.branch_taken) begin
              pc_set_c      = 1'b1;
              pc_set_addr_c = bus.branch_target_addr;
              flush_if_c    = 1'b1;
              flush_id_c    = 1'b1;
              if (!lsu_load_gnt_c) state_d = FLUSH;
            end else if (bus.id_jump) begin
              pc_set_c      = 1'b1;
              pc_set_addr_c = bus.jump_target_addr;
              flush_if_c    = 1'b1;
            end else if (load_use_c) begin
              lu_stall_c = 1'b1;
              flush_id_c = 1'b1;
            end
          end
        end
      end
      LSU_REQ: begin
        lsu_stall_c = 1'b1;
        if (bus.data_gnt) state_d = bus.mem_lsu_wr_type ? RUN : LSU_WAIT;
      end
      LSU_WAIT: begin
        if (bus.data_rvalid) state_d = RUN;
        else                 lsu_stall_c = 1'b1;
      end
      default: state_d = RUN;
    endcase

    stall_ex_c = lsu_stall_c;
    stall_if_c = lsu_stall_c || lu_stall_c || !bus.ex_stage_ready;
    stall_id_c = stall_if_c;

    // Reset holds every control output quiet regardless of inputs.
    if (!reset_n) begin
      stall_ex_c    = 1'b0;
      stall_if_c    = 1'b0;
      stall_id_c    = 1'b0;
      flush_if_c    = 1'b0;
      flush_id_c    = 1'b0;
      pc_set_c      = 1'b0;
      pc_set_addr_c = '0;
    end
  end

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + PERF_STALL_W'(stall_if_c);
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (pc_set_c && (perf_flush_cnt_q != PERF_FLUSH_MAX))
      perf_flush_cnt_d = perf_flush_cnt_q + PERF_FLUSH_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= RUN;
      perf_stall_cnt_q <= PERF_STALL_RST;
      perf_flush_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign bus.stall_if       = stall_if_c;
  assign bus.stall_id       = stall_id_c;
  assign bus.stall_ex_stage = stall_ex_c;
  assign bus.flush_if       = flush_if_c;
  assign bus.flush_id       = flush_id_c;
  assign bus.pc_set         = pc_set_c;
  assign bus.pc_set_addr    = pc_set_addr_c;
  assign bus.perf_stall_cnt = perf_stall_cnt_q;
  assign bus.perf_flush_cnt = perf_flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, redirects, LSU stalls, counters, reset.
module tb_pipe_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl_if bus_w ();

  pipe_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Second instance starts its stall counter at all-ones to reach the wrap quickly.
  pipe_ctrl #(.PERF_STALL_RST(32'hFFFF_FFFF)) dut_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w.slave)
  );

  int unsigned  n_checks;
  int unsigned  n_errors;
  logic [31:0]  exp_stall;
  logic [31:0]  exp_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;           bus.id_rs1_addr = '0;        bus.id_rs2_addr = '0;
    bus.id_rs1_used = 1'b0;        bus.id_rs2_used = 1'b0;      bus.load_instr_in_ex = 1'b0;
    bus.ex_dest_we_addr = '0;      bus.ex_stage_ready = 1'b1;   bus.branch_taken = 1'b0;
    bus.branch_target_addr = '0;   bus.id_jump = 1'b0;          bus.jump_target_addr = '0;
    bus.mem_lsu_valid = 1'b0;      bus.mem_lsu_wr_type = 1'b0;  bus.data_gnt = 1'b0;
    bus.data_rvalid = 1'b0;
  endtask

  task automatic idle_w();
    bus_w.id_valid = 1'b0;         bus_w.id_rs1_addr = '0;      bus_w.id_rs2_addr = '0;
    bus_w.id_rs1_used = 1'b0;      bus_w.id_rs2_used = 1'b0;    bus_w.load_instr_in_ex = 1'b0;
    bus_w.ex_dest_we_addr = '0;    bus_w.ex_stage_ready = 1'b1; bus_w.branch_taken = 1'b0;
    bus_w.branch_target_addr = '0; bus_w.id_jump = 1'b0;        bus_w.jump_target_addr = '0;
    bus_w.mem_lsu_valid = 1'b0;    bus_w.mem_lsu_wr_type = 1'b0; bus_w.data_gnt = 1'b0;
    bus_w.data_rvalid = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are then driven and sampled #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    reset_n   = 1'b0;
    idle();
    idle_w();
    bus.branch_taken       = 1'b1;
    bus.branch_target_addr = 32'h44;
    bus.ex_stage_ready     = 1'b0;
    #2;
    check("rst_pc_set",     32'(bus.pc_set),         32'd0);
    check("rst_pc_addr",    bus.pc_set_addr,         32'd0);
    check("rst_flush_if",   32'(bus.flush_if),       32'd0);
    check("rst_stall_if",   32'(bus.stall_if),       32'd0);
    check("rst_stall_ex",   32'(bus.stall_ex_stage), 32'd0);
    check("rst_stall_cnt",  bus.perf_stall_cnt,      32'd0);
    check("rst_flush_cnt",  32'(bus.perf_flush_cnt), 32'd0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;

    // Stall counter wrap on the preloaded instance
    cyc();
    check("wrap_preload", bus_w.perf_stall_cnt, 32'hFFFF_FFFF);
    bus_w.ex_stage_ready = 1'b0;
    #1 check("wrap_stall_if", 32'(bus_w.stall_if), 32'd1);
    cyc();
    bus_w.ex_stage_ready = 1'b1;
    check("wrap_to_zero", bus_w.perf_stall_cnt, 32'd0);

    // Load-use on rs1 = x5
    bus.load_instr_in_ex = 1'b1; bus.ex_dest_we_addr = 5'd5;
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd5; bus.id_rs1_used = 1'b1;
    #1;
    check("lu_stall_if", 32'(bus.stall_if),       32'd1);
    check("lu_stall_id", 32'(bus.stall_id),       32'd1);
    check("lu_flush_id", 32'(bus.flush_id),       32'd1);
    check("lu_stall_ex", 32'(bus.stall_ex_stage), 32'd0);
    exp_stall++;
    cyc();
    bus.load_instr_in_ex = 1'b0;
    #1 check("lu_release", 32'(bus.stall_if), 32'd0);
    cyc();
    bus.load_instr_in_ex = 1'b1; bus.ex_dest_we_addr = 5'd0; bus.id_rs1_addr = 5'd0;
    #1 check("lu_x0_none", 32'(bus.stall_if), 32'd0);
    cyc();
    bus.ex_dest_we_addr = 5'd9; bus.id_rs1_addr = 5'd1;
    bus.id_rs2_addr = 5'd9; bus.id_rs2_used = 1'b0;
    #1 check("lu_rs2_unused", 32'(bus.stall_if), 32'd0);
    cyc();
    bus.id_rs2_used = 1'b1;
    #1 check("lu_rs2_used", 32'(bus.stall_if), 32'd1);
    exp_stall++;
    cyc();
    idle();
    bus.ex_stage_ready = 1'b0;
    #1;
    check("exr_stall_if", 32'(bus.stall_if),       32'd1);
    check("exr_stall_id", 32'(bus.stall_id),       32'd1);
    check("exr_stall_ex", 32'(bus.stall_ex_stage), 32'd0);
    exp_stall++;

    // Taken branch wins over a simultaneous jump, then one FLUSH cycle
    cyc();
    idle();
    bus.branch_taken = 1'b1; bus.branch_target_addr = 32'h100;
    bus.id_jump = 1'b1;      bus.jump_target_addr = 32'h200;
    #1;
    check("br_pc_set",   32'(bus.pc_set),   32'd1);
    check("br_pc_addr",  bus.pc_set_addr,   32'h100);
    check("br_flush_if", 32'(bus.flush_if), 32'd1);
    check("br_flush_id", 32'(bus.flush_id), 32'd1);
    exp_flush++;
    cyc();
    bus.load_instr_in_ex = 1'b1; bus.ex_dest_we_addr = 5'd3;
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd3; bus.id_rs1_used = 1'b1;
    #1;
    check("fl_pc_set",   32'(bus.pc_set),   32'd0);
    check("fl_flush_if", 32'(bus.flush_if), 32'd0);
    check("fl_stall_if", 32'(bus.stall_if), 32'd0);
    check("fl_cnt",      32'(bus.perf_flush_cnt), exp_flush);
    cyc();
    idle();
    bus.id_jump = 1'b1; bus.jump_target_addr = 32'h200;
    #1;
    check("jmp_pc_set",   32'(bus.pc_set),   32'd1);
    check("jmp_pc_addr",  bus.pc_set_addr,   32'h200);
    check("jmp_flush_if", 32'(bus.flush_if), 32'd1);
    check("jmp_flush_id", 32'(bus.flush_id), 32'd0);
    exp_flush++;
    cyc();
    idle();
    bus.load_instr_in_ex = 1'b1; bus.ex_dest_we_addr = 5'd7;
    bus.id_valid = 1'b1; bus.id_rs2_addr = 5'd7; bus.id_rs2_used = 1'b1;
    #1 check("jmp_stays_run", 32'(bus.stall_if), 32'd1);
    exp_stall++;

    // Load: grant two cycles late, rvalid three cycles after grant
    cyc();
    idle();
    bus.mem_lsu_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) bus.data_gnt = 1'b1;
      if (c == 3) begin bus.data_gnt = 1'b0; bus.mem_lsu_valid = 1'b0; end
      if (c == 5) bus.data_rvalid = 1'b1;
      #1;
      check($sformatf("ld_stall_if_%0d", c), 32'(bus.stall_if),       (c < 5) ? 32'd1 : 32'd0);
      check($sformatf("ld_stall_ex_%0d", c), 32'(bus.stall_ex_stage), (c < 5) ? 32'd1 : 32'd0);
      if (c < 5) exp_stall++;
      cyc();
    end
    idle();
    check("ld_stall_cnt", bus.perf_stall_cnt, exp_stall);

    // Store: stalls until granted, returns straight to RUN
    bus.mem_lsu_valid = 1'b1; bus.mem_lsu_wr_type = 1'b1;
    #1 check("st_req", 32'(bus.stall_id), 32'd1);
    exp_stall++;
    cyc();
    bus.data_gnt = 1'b1;
    #1 check("st_gnt", 32'(bus.stall_id), 32'd1);
    exp_stall++;
    cyc();
    idle();
    #1 check("st_done", 32'(bus.stall_if), 32'd0);

    // Immediate grant adds no stall; branch held across the wait acts after rvalid
    cyc();
    bus.mem_lsu_valid = 1'b1; bus.data_gnt = 1'b1;
    #1 check("ig_no_stall", 32'(bus.stall_if), 32'd0);
    cyc();
    idle();
    bus.branch_taken = 1'b1; bus.branch_target_addr = 32'h300;
    #1;
    check("bw_stall", 32'(bus.stall_if), 32'd1);
    check("bw_no_pc", 32'(bus.pc_set),   32'd0);
    exp_stall++;
    cyc();
    bus.data_rvalid = 1'b1;
    #1 check("bw_rvalid_no_pc", 32'(bus.pc_set), 32'd0);
    cyc();
    bus.data_rvalid = 1'b0;
    #1;
    check("bw_pc_set",  32'(bus.pc_set), 32'd1);
    check("bw_pc_addr", bus.pc_set_addr, 32'h300);
    exp_flush++;
    cyc();
    idle();
    check("mid_stall_cnt", bus.perf_stall_cnt,      exp_stall);
    check("mid_flush_cnt", 32'(bus.perf_flush_cnt), exp_flush);

    // Reset while waiting on a load; a late rvalid must be ignored
    cyc();
    bus.mem_lsu_valid = 1'b1; bus.data_gnt = 1'b1;
    cyc();
    idle();
    #1 check("rw_wait_stall", 32'(bus.stall_ex_stage), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rw_stall_if",  32'(bus.stall_if),       32'd0);
    check("rw_stall_ex",  32'(bus.stall_ex_stage), 32'd0);
    check("rw_stall_cnt", bus.perf_stall_cnt,      32'd0);
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    cyc();
    reset_n = 1'b1;
    bus.data_rvalid = 1'b1;
    #1 check("rw_late_rvalid", 32'(bus.stall_if), 32'd0);
    cyc();
    bus.data_rvalid = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target_addr = 32'h400;
    #1;
    check("rw_run_pc_set",  32'(bus.pc_set), 32'd1);
    check("rw_run_pc_addr", bus.pc_set_addr, 32'h400);
    cyc();
    idle();

    // Flush counter saturation
    cyc();
    bus.id_jump = 1'b1; bus.jump_target_addr = 32'h500;
    #1 check("sat_pc_set", 32'(bus.pc_set), 32'd1);
    repeat (65536) cyc();
    idle();
    check("sat_flush_cnt", 32'(bus.perf_flush_cnt), 32'h0000_FFFF);
    check("sat_stall_cnt", bus.perf_stall_cnt,      exp_stall);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 clock; reset_n input 1 asynchronous active-low reset.
REQ-002 SHALL have id_valid input 1, meaning a valid instruction is in ID.
REQ-003 SHALL have id_rs1_addr and id_rs2_addr inputs 5 each, plus id_rs1_used and id_rs2_used inputs 1 each, giving the ID source registers and their use flags.
REQ-004 SHALL have load_instr_in_ex input 1, ex_dest_we_addr input 5 and ex_stage_ready input 1, all sourced from EX.
REQ-005 SHALL have branch_taken input 1 and branch_target_addr input 32, sourced from EX.
REQ-006 SHALL have id_jump input 1 and jump_target_addr input 32, sourced from ID/EX.
REQ-007 SHALL have the following data-bus inputs:
- mem_lsu_valid 1
- mem_lsu_wr_type 1 (1 = store)
- data_gnt 1
- data_rvalid 1
REQ-008 SHALL have stall outputs stall_if, stall_id and stall_ex_stage, each 1.
REQ-009 SHALL have flush outputs flush_if (kill IF/ID register) and flush_id (inject bubble into EX), each 1.
REQ-010 SHALL have redirect outputs pc_set 1 and pc_set_addr 32.
REQ-011 SHALL have perf outputs perf_stall_cnt 32 and perf_flush_cnt 16.

Function
REQ-012 SHALL implement FSM states RUN, LSU_REQ, LSU_WAIT, FLUSH; state register only, outputs combinational from state plus inputs.
REQ-013 RUN -> LSU_REQ SHALL occur when mem_lsu_valid=1 and data_gnt=0.
REQ-014 RUN or LSU_REQ, on data_gnt=1 for a load -> LSU_WAIT; a store -> RUN; data_gnt=1 in the request cycle SHALL add no stall.
REQ-015 LSU_WAIT -> RUN SHALL occur on data_rvalid=1; stall ends the same cycle.
REQ-016 In LSU_REQ and LSU_WAIT (and RUN with mem_lsu_valid & ~data_gnt), stall_if, stall_id and stall_ex_stage SHALL all be 1.
REQ-017 Load-use: in RUN, if load_instr_in_ex=1, id_valid=1, ex_dest_we_addr!=0 and it matches a used rs, then stall_if=1, stall_id=1 and flush_id=1 for exactly 1 cycle.
REQ-018 Taken branch: in RUN, if branch_taken=1, then pc_set=1, pc_set_addr=branch_target_addr, flush_if=1 and flush_id=1 in the same cycle; next state FLUSH.
REQ-019 Jump: in RUN, if id_jump=1 and no branch_taken, then pc_set=1, pc_set_addr=jump_target_addr and flush_if=1; the state stays RUN.
REQ-020 FLUSH SHALL last exactly 1 cycle and then return to RUN; during it, branch_taken, id_jump and load-use are ignored, and LSU stall still applies.
REQ-021 Priority SHALL be: LSU stall > branch_taken > id_jump > load-use.
REQ-022 A branch_taken held during an LSU stall SHALL be acted on in the first cycle after the stall releases.
REQ-023 ex_stage_ready=0 SHALL force stall_if=1 and stall_id=1, with stall_ex_stage unaffected.
REQ-024 perf_stall_cnt SHALL increment every cycle stall_if=1 and wrap from 0xFFFFFFFF to 0.
REQ-025 perf_flush_cnt SHALL increment on every pc_set=1 and saturate at 0xFFFF.

Reset
REQ-026 Asserting reset_n=0 SHALL asynchronously force state RUN, both counters 0, and all stall, flush and pc_set outputs 0 with pc_set_addr=0.
REQ-027 Reset asserted in LSU_WAIT SHALL abandon the outstanding load; a data_rvalid arriving after reset release SHALL be ignored in RUN.

Structure
REQ-028 The pipe_state_e enum and the PERF_FLUSH_MAX constant SHALL reside in riscv_pkg.
REQ-029 Load-use detection SHALL be a combinational sub-module named pipe_hazard_unit.
REQ-030 The FSM, priority logic and counters SHALL reside in pipe_ctrl.

Verification
REQ-031 Load-use: load x5 in EX, ID uses rs1=x5 -> one cycle of stall_if, stall_id and flush_id, then stall_if=0; ex_dest_we_addr=0 -> no stall.
REQ-032 Taken branch with target 0x00000100 -> same-cycle pc_set=1, pc_set_addr=0x100, flush_if=1, flush_id=1; one FLUSH cycle; perf_flush_cnt +1.
REQ-033 Load with data_gnt delayed 2 cycles and data_rvalid 3 cycles later -> all three stalls high for 5 cycles; perf_stall_cnt +5.
REQ-034 branch_taken concurrent with an LSU stall -> no pc_set during the stall; pc_set in the cycle after data_rvalid.
REQ-035 Preload perf_stall_cnt 0xFFFFFFFF and stall one cycle -> 0; drive 0x10000 redirects -> perf_flush_cnt=0xFFFF.
REQ-036 Assert reset_n in LSU_WAIT -> state RUN and all stalls 0 immediately; a late data_rvalid produces no effect.
